// File: rtl/xoodoo_perm_core.sv
// xoodoo_perm_core: iterative Xoodoo permutation, one round per clock, with its round-constant generator.
// rc = {1,s} << q; s steps as x*s mod x^3+x+1, q cycles 3,2,6,4,5,1.
module xoodoo_rc (
    input  logic [5:0]  state,
    output logic [31:0] rc,
    output logic [5:0]  state_out
);
    logic [2:0] q, s;
    assign {q, s} = state;
    assign rc = 32'({1'b1, s}) << q;
    assign state_out = {~q[0], ~q[2], ~q[1], s[1], s[0] ^ s[2], s[2]};
endmodule

module xoodoo_perm_core #(
    parameter int         NUM_ROUNDS = 12,
    parameter logic [5:0] RC_INIT    = 6'b011011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [383:0] state_in,
    output logic         busy,
    output logic         done,
    output logic [383:0] state_out
);
    typedef enum logic {IDLE, RUN} fsm_t;
    fsm_t fsm;
    logic [383:0] st, nxt;
    logic [5:0] rc_reg, rc_next;
    logic [31:0] rc;
    logic [3:0] round_cnt;
    logic [3:0][31:0] p, e, t0, t1, t2, c0, c1, c2;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    xoodoo_rc u_rc (.state(rc_reg), .rc(rc), .state_out(rc_next));

    // theta, rho-west and iota fold into t*; chi into c*; rho-east on the way out
    for (genvar x = 0; x < 4; x++) begin : g_lane
        assign p[x]  = st[x*32 +: 32] ^ st[(x+4)*32 +: 32] ^ st[(x+8)*32 +: 32];
        assign e[x]  = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
        assign t0[x] = st[x*32 +: 32] ^ e[x] ^ ((x == 0) ? rc : 32'd0);
        assign t1[x] = st[((x+3)%4+4)*32 +: 32] ^ e[(x+3)%4];
        assign t2[x] = rotl(st[(x+8)*32 +: 32] ^ e[x], 11);
        assign c0[x] = t0[x] ^ (~t1[x] & t2[x]);
        assign c1[x] = t1[x] ^ (~t2[x] & t0[x]);
        assign c2[x] = t2[x] ^ (~t0[x] & t1[x]);
        assign nxt[x*32 +: 32]     = c0[x];
        assign nxt[(x+4)*32 +: 32] = rotl(c1[x], 1);
        assign nxt[(x+8)*32 +: 32] = rotl(c2[(x+2)%4], 8);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            st        <= '0;
            rc_reg    <= RC_INIT;
            round_cnt <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fsm == IDLE) begin
                if (start) begin
                    st        <= state_in;
                    rc_reg    <= RC_INIT;
                    round_cnt <= '0;
                    fsm       <= RUN;
                end
            end else begin
                st        <= nxt;
                rc_reg    <= rc_next;
                round_cnt <= round_cnt + 4'd1;
                if (round_cnt == 4'(NUM_ROUNDS - 1)) begin
                    fsm  <= IDLE;
                    done <= 1'b1;
                end
            end
        end
    end

    assign busy      = (fsm == RUN);
    assign state_out = st;
endmodule

// File: tb/tb_xoodoo_perm_core.sv
// tb_xoodoo_perm_core: directed checks of the Xoodoo core against an independent reference model.
module tb_xoodoo_perm_core;
    logic clk = 0, rst = 1, start = 0, start1 = 0;
    logic [383:0] state_in = '0, state_in1 = '0;
    logic busy, done, busy1, done1;
    logic [383:0] state_out, state_out1;
    int n_vec = 0, n_err = 0;
    logic [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                                 32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};
    logic [31:0] rc_seen [12];
    logic [383:0] v0, v1, v2;

    always #5 clk = ~clk;

    xoodoo_perm_core dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in),
        .busy(busy), .done(done), .state_out(state_out)
    );

    xoodoo_perm_core #(.NUM_ROUNDS(1), .RC_INIT(6'b001001)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .state_in(state_in1),
        .busy(busy1), .done(done1), .state_out(state_out1)
    );

    function automatic logic [31:0] rl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    // textbook step-by-step Xoodoo with a fixed rc table, lanes a[4*y+x]
    function automatic logic [383:0] ref_perm(input logic [383:0] s, input int nr);
        logic [31:0] a [12];
        logic [31:0] b [12];
        logic [31:0] p [4];
        logic [31:0] e [4];
        logic [383:0] r;
        for (int i = 0; i < 12; i++) a[i] = s[i*32 +: 32];
        for (int k = 12 - nr; k < 12; k++) begin
            for (int x = 0; x < 4; x++) p[x] = a[x] ^ a[4+x] ^ a[8+x];
            for (int x = 0; x < 4; x++) e[x] = rl(p[(x+3)%4], 5) ^ rl(p[(x+3)%4], 14);
            for (int i = 0; i < 12; i++) a[i] = a[i] ^ e[i%4];
            b = a;
            for (int x = 0; x < 4; x++) begin
                a[4+x] = b[4+(x+3)%4];
                a[8+x] = rl(b[8+x], 11);
            end
            a[0] = a[0] ^ rc_tab[k];
            b = a;
            for (int x = 0; x < 4; x++) begin
                a[x]   = b[x]   ^ (~b[4+x] & b[8+x]);
                a[4+x] = b[4+x] ^ (~b[8+x] & b[x]);
                a[8+x] = b[8+x] ^ (~b[x]   & b[4+x]);
            end
            b = a;
            for (int x = 0; x < 4; x++) begin
                a[4+x] = rl(b[4+x], 1);
                a[8+x] = rl(b[8+(x+2)%4], 8);
            end
        end
        for (int i = 0; i < 12; i++) r[i*32 +: 32] = a[i];
        return r;
    endfunction

    // launch one call from an idle core and wait (bounded) for done; lat counts cycles from the start cycle
    task automatic do_call(input logic [383:0] v, output int lat, output int nbusy);
        start = 1; state_in = v;
        @(negedge clk);
        start = 0; lat = 1; nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) begin
                if (nbusy < 12) rc_seen[nbusy] = dut.rc;
                nbusy++;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 1; start1 = 1; state_in = '1; state_in1 = '1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
            n_vec++; if (state_out !== '0) begin n_err++; $display("FAIL reset_state got %h want 0", state_out); end
            n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got %b want 0", busy1); end
        end
        rst = 0; start = 0; start1 = 0; state_in = '0; state_in1 = '0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_no_start got %b want 0", busy); end
    endtask

    task automatic test_single_round();
        logic [383:0] exp;
        exp = '0; exp[31:0] = 32'h00000012; exp[159:128] = 32'h00000024;
        start1 = 1; state_in1 = '0;
        @(negedge clk);
        start1 = 0;
        n_vec++; if (busy1 !== 1'b1) begin n_err++; $display("FAIL r1_busy got %b want 1", busy1); end
        n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL r1_done_early got %b want 0", done1); end
        @(negedge clk);
        n_vec++; if (done1 !== 1'b1) begin n_err++; $display("FAIL r1_done got %b want 1", done1); end
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL r1_busy_end got %b want 0", busy1); end
        n_vec++; if (state_out1 !== exp) begin n_err++; $display("FAIL r1_state got %h want %h", state_out1, exp); end
        n_vec++; if (state_out1 !== ref_perm('0, 1)) begin n_err++; $display("FAIL r1_model got %h want %h", state_out1, ref_perm('0, 1)); end
        @(negedge clk);
        n_vec++; if (done1 !== 1'b0) begin n_err++; $display("FAIL r1_pulse got %b want 0", done1); end
    endtask

    task automatic test_default();
        int lat, nb;
        logic [383:0] vs [2];
        logic [383:0] exp;
        vs[0] = v0; vs[1] = v1;
        for (int t = 0; t < 2; t++) begin
            exp = ref_perm(vs[t], 12);
            do_call(vs[t], lat, nb);
            n_vec++; if (lat != 13) begin n_err++; $display("FAIL def%0d_latency got %0d want 13", t, lat); end
            n_vec++; if (nb != 12) begin n_err++; $display("FAIL def%0d_busy_cycles got %0d want 12", t, nb); end
            n_vec++; if (state_out !== exp) begin n_err++; $display("FAIL def%0d_state got %h want %h", t, state_out, exp); end
            if (t == 0)
                for (int i = 0; i < 12; i++) begin
                    n_vec++; if (rc_seen[i] !== rc_tab[i]) begin n_err++; $display("FAIL rc%0d got %h want %h", i, rc_seen[i], rc_tab[i]); end
                end
            @(negedge clk);
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL def%0d_pulse got %b want 0", t, done); end
            n_vec++; if (state_out !== exp) begin n_err++; $display("FAIL def%0d_hold got %h want %h", t, state_out, exp); end
        end
    endtask

    task automatic test_start_while_busy();
        int cyc, ndone, lat;
        logic [383:0] res, exp;
        exp = ref_perm(v1, 12);
        ndone = 0; lat = 0; res = '0;
        start = 1; state_in = v1;
        @(negedge clk);
        start = 0;
        for (cyc = 1; cyc <= 20; cyc++) begin
            if (done) begin ndone++; lat = cyc; res = state_out; end
            if (cyc == 3 || cyc == 11) begin start = 1; state_in = '1; end
            else start = 0;
            @(negedge clk);
        end
        n_vec++; if (ndone != 1) begin n_err++; $display("FAIL swb_done_count got %0d want 1", ndone); end
        n_vec++; if (lat != 13) begin n_err++; $display("FAIL swb_latency got %0d want 13", lat); end
        n_vec++; if (res !== exp) begin n_err++; $display("FAIL swb_state got %h want %h", res, exp); end
        n_vec++; if (state_out !== exp) begin n_err++; $display("FAIL swb_hold got %h want %h", state_out, exp); end
    endtask

    task automatic test_back_to_back();
        logic [383:0] vs [3];
        int k, cyc, last;
        vs[0] = v0; vs[1] = v1; vs[2] = v2;
        k = 0; cyc = 0; last = 0;
        start = 1; state_in = vs[0];
        while (k < 3 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                n_vec++; if (state_out !== ref_perm(vs[k], 12)) begin n_err++; $display("FAIL b2b%0d_state got %h want %h", k, state_out, ref_perm(vs[k], 12)); end
                n_vec++; if (cyc - last != 13) begin n_err++; $display("FAIL b2b%0d_period got %0d want 13", k, cyc - last); end
                last = cyc;
                k++;
                if (k < 3) state_in = vs[k];
                else start = 0;
            end
        end
        start = 0;
        n_vec++; if (k != 3) begin n_err++; $display("FAIL b2b_calls got %0d want 3", k); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int ndone, lat, nb;
        start = 1; state_in = v1;
        @(negedge clk);
        start = 0;
        repeat (5) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy got %b want 1", busy); end
        rst = 1;
        @(negedge clk);
        rst = 0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_abort_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_abort_done got %b want 0", done); end
        n_vec++; if (state_out !== '0) begin n_err++; $display("FAIL mid_abort_state got %h want 0", state_out); end
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_vec++; if (ndone != 0) begin n_err++; $display("FAIL mid_stray_done got %0d want 0", ndone); end
        do_call(v1, lat, nb);
        n_vec++; if (lat != 13) begin n_err++; $display("FAIL mid_restart_latency got %0d want 13", lat); end
        n_vec++; if (state_out !== ref_perm(v1, 12)) begin n_err++; $display("FAIL mid_restart_state got %h want %h", state_out, ref_perm(v1, 12)); end
    endtask

    initial begin
        v0 = '0;
        for (int i = 0; i < 48; i++) v1[i*8 +: 8] = 8'(i);
        v2 = {12{32'h9e3779b9}};
        test_reset();
        test_single_round();
        test_default();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/xoodoo_perm_core.md
Name: xoodoo_perm_core

Overview:
- Iterative Xoodoo permutation engine, one round per clock. It sits directly downstream of the round-constant generator xoodoo_rc, which it instantiates.
- The core holds the 6-bit rc state register, feeds it to xoodoo_rc, consumes `rc` and `state_out` each round, and applies theta, rho-west, iota, chi and rho-east to a 384-bit state.
- The Xoodyak AEAD/hash controller uses it via a start/done handshake.

Parameters:
- NUM_ROUNDS, 12: rounds per permutation call, legal range 1..12.
- RC_INIT, 6'b011011: rc state loaded at start, as {qi[2:0], si[2:0]}. The default gives first rc 0x058 and last rc 0x012 for 12 rounds.

Ports:
- clk  in  1  single clock; all flops on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a permutation; sampled only when not busy.
- state_in  in  384  input state, sampled on the accepted start edge.
- busy  out  1  high while rounds are in progress.
- done  out  1  one-cycle pulse; state_out is valid from this cycle.
- state_out  out  384  permuted state; held until the next accepted start.

Behaviour:
- Lane mapping: lane (x,y), x=0..3 and y=0..2, occupies bits [(4*y+x)*32 +: 32] of state_in and state_out. Plane Ay[x] is lane (x,y). All x indices are mod 4. rotl is a 32-bit left rotate.
- One round, in order:
  - theta: P[x]=A0[x]^A1[x]^A2[x]; E[x]=rotl(P[x-1],5)^rotl(P[x-1],14); Ay[x]^=E[x].
  - rho-west: A1[x]=A1[x-1]; A2[x]=rotl(A2[x],11).
  - iota: A0[0]^=rc, where rc is the xoodoo_rc output for the current rc state.
  - chi: B0=~A1&A2; B1=~A2&A0; B2=~A0&A1; Ay^=By.
  - rho-east: A1[x]=rotl(A1[x],1); A2[x]=rotl(A2[x+2],8).
- FSM state IDLE:
  - busy=0.
  - On start=1: load the state register from state_in, rc_reg=RC_INIT, round_cnt=0, go to RUN.
  - done is not asserted on the load edge.
- FSM state RUN:
  - busy=1.
  - Each edge: state register <= round(state, rc); rc_reg <= xoodoo_rc state_out; round_cnt++.
  - On the edge that completes round NUM_ROUNDS: go to IDLE and set done=1 for exactly one cycle.
- round_cnt: 4 bits wide; it never wraps within a legal NUM_ROUNDS.
- Latency: start sampled at edge k; rounds execute on edges k+1..k+NUM_ROUNDS.
  - busy is high for NUM_ROUNDS cycles.
  - done is high in the cycle after edge k+NUM_ROUNDS.
  - For the default, start to done is 13 cycles.
- state_out is driven directly from the state register.
  - While busy=1 its value is intermediate and must not be consumed.
  - After done it holds until the next accepted start.
- start while busy=1 is ignored: no restart, no queueing.
- start in the same cycle as done=1 (IDLE) is accepted:
  - the new state loads on that edge;
  - busy rises next cycle;
  - done drops normally.
- Reset value of every output: busy=0, done=0, state_out=0. Internal reset values: FSM=IDLE, rc_reg=RC_INIT, round_cnt=0.
- rst=1 mid-RUN aborts at the next edge. No done is produced for the aborted call.
- rst has priority over start in the same cycle.

Test Plan:
1. Reset. Assert rst for 2 cycles with start=1 and state_in=all ones -> busy=0, done=0, state_out=0; no permutation starts.
2. Single round, NUM_ROUNDS=1, RC_INIT=6'b001001 (rc 0x012). Start with state_in=0 -> done 2 cycles after start; word0=0x00000012, word4=0x00000024, all other words 0.
3. Default, 12 rounds. Apply state_in=0 and state_in=incrementing bytes 0x00..0x2F -> each output matches the golden Xoodoo[12] software model. busy is high for exactly 12 cycles and done pulses 13 cycles after start. The rc sequence probed at iota must be 058,038,3C0,0D0,120,014,060,02C,380,0F0,1A0,012.
4. Start while busy. Pulse start again at cycles 3 and 11 of a run, with a different state_in -> those starts are ignored; result equals the single-call result; done pulses once.
5. Back-to-back. Hold start=1 continuously -> new calls begin in each done cycle; done pulses every 13 cycles; each result is the permutation of the state_in sampled at its start.
6. Reset mid-run. Assert rst at round 6 -> next cycle busy=0, done=0, state_out=0. A following start yields the correct full result.
